gshare_predictor: RTL

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/bp_pkg.sv | 26 ++
 rtl/pht_ram.sv | 35 +++
 rtl/gshare_predictor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and counter helpers for the gshare branch predictor
package bp_pkg;

    typedef enum logic {
        INIT,
        READY
    } bp_state_e;

    // Helpers work on the widest legal counter (4 bits); callers truncate to CTR_BITS.
    function automatic logic [3:0] ctr_max(input int bits);
        return 4'((1 << bits) - 1);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] ctr, input int bits);
        return (ctr >= ctr_max(bits)) ? ctr_max(bits) : ctr + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] ctr);
        return (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
    endfunction

    function automatic logic [3:0] weak_not_taken(input int bits);
        return 4'((1 << (bits - 1)) - 1);
    endfunction

endpackage

// File: rtl/pht_ram.sv
// rtl/pht_ram.sv - 1R/1W synchronous pattern history table with write-to-read bypass
module pht_ram #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 2
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata
);

    logic [DATA_BITS-1:0] mem [0:(1 << ADDR_BITS)-1];
    logic [DATA_BITS-1:0] rdata_q;
    logic [DATA_BITS-1:0] rdata_d;

    // A colliding write wins so the reader never sees the stale entry.
    always_comb begin
        rdata_d = mem[raddr];
        if (we && (waddr == raddr)) begin
            rdata_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with speculative global history
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int GHR_BITS   = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [31:0]           fetch_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [CTR_BITS-1:0]   pred_ctr,
    output logic [GHR_BITS-1:0]   pred_ghr,
    input  logic                  res_valid,
    input  logic [31:0]           res_pc,
    input  logic [GHR_BITS-1:0]   res_ghr,
    input  logic [CTR_BITS-1:0]   res_ctr,
    input  logic                  res_branch,
    input  logic                  res_jump,
    input  logic                  res_taken,
    input  logic                  res_mispredict,
    output logic                  init_busy
);

    bp_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] walk_q, walk_d;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [GHR_BITS-1:0]   pred_ghr_q, pred_ghr_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  init_busy_q, init_busy_d;

    logic                  ready;
    logic                  lookup_acc;
    logic                  res_write;
    logic                  res_recover;
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [CTR_BITS-1:0]   res_next;
    logic                  ram_we;
    logic [INDEX_BITS-1:0] ram_waddr;
    logic [CTR_BITS-1:0]   ram_wdata;
    logic [CTR_BITS-1:0]   ram_rdata;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0],
                              res_pc[31:INDEX_BITS+2], res_pc[1:0]};

    always_comb begin
        ready       = (state_q == READY);
        lookup_acc  = fetch_valid && ready;
        res_write   = res_valid && ready && (res_branch || res_jump);
        res_recover = res_valid && ready && res_mispredict;
        rd_idx      = fetch_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
        wr_idx      = res_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(res_ghr);

        if (res_jump) begin
            res_next = '1;
        end else if (res_taken) begin
            res_next = CTR_BITS'(sat_inc(4'(res_ctr), CTR_BITS));
        end else begin
            res_next = CTR_BITS'(sat_dec(4'(res_ctr)));
        end

        // The init walker owns the write port until the table is fully seeded.
        if (state_q == INIT) begin
            ram_we    = 1'b1;
            ram_waddr = walk_q;
            ram_wdata = CTR_BITS'(weak_not_taken(CTR_BITS));
        end else begin
            ram_we    = res_write;
            ram_waddr = wr_idx;
            ram_wdata = res_next;
        end
    end

    always_comb begin
        state_d      = state_q;
        walk_d       = walk_q;
        ghr_d        = ghr_q;
        pred_valid_d = lookup_acc;
        pred_ghr_d   = lookup_acc ? ghr_q : '0;

        if (state_q == INIT) begin
            walk_d = walk_q + 1'b1;
            if (walk_q == '1) begin
                state_d = READY;
            end
        end else if (res_recover) begin
            ghr_d = GHR_BITS'({res_ghr, res_taken});
        end else if (pred_valid_q) begin
            // Speculative history: shift in the direction just predicted.
            ghr_d = GHR_BITS'({ghr_q, ram_rdata[CTR_BITS-1]});
        end

        init_busy_d = (state_d == INIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            walk_q       <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_ghr_q   <= '0;
            init_busy_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            walk_q       <= walk_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_ghr_q   <= pred_ghr_d;
            init_busy_q  <= init_busy_d;
        end
    end

    pht_ram #(
        .ADDR_BITS (INDEX_BITS),
        .DATA_BITS (CTR_BITS)
    ) u_pht (
        .clk   (clk),
        .raddr (rd_idx),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    assign pred_valid = pred_valid_q;
    assign pred_ctr   = pred_valid_q ? ram_rdata : '0;
    assign pred_taken = pred_ctr[CTR_BITS-1];
    assign pred_ghr   = pred_ghr_q;
    assign init_busy  = init_busy_q;

endmodule
